// File: rtl/frame_ctrl_pkg.sv
// Shared types and helpers for the frame block controller.
//   fbc_state_t       - controller FSM state encoding
//   WIN_PER_LOAD_DEF  - default calc_done pulses expected per loaded block
//   idx_width()       - index width for a count, never narrower than one bit
package frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    LOAD,
    CALC,
    DONE
  } fbc_state_t;

  localparam int unsigned WIN_PER_LOAD_DEF = 4;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_position_counter.sv
// Row-major block position tracker for one frame.
//   clk, n_rst  - clock, asynchronous active-low reset
//   clear       - return to block (0,0); has priority over advance
//   advance     - step to the next block (ignored on the last block)
//   col, row    - current block column / row
//   last_block  - current block is the final one of the frame
module block_position_counter
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 4,
  parameter int unsigned ROWS = 4,
  localparam int unsigned ColW = idx_width(COLS),
  localparam int unsigned RowW = idx_width(ROWS)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            advance,
  output logic [ColW-1:0] col,
  output logic [RowW-1:0] row,
  output logic            last_block
);

  localparam logic [ColW-1:0] ColMax = ColW'(COLS - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(ROWS - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  assign last_block = (col_q == ColMax) && (row_q == RowMax);
  assign col        = col_q;
  assign row        = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance && !last_block) begin
      // Gating on last_block keeps both indices inside their ranges.
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/frame_block_controller.sv
// Sequences one frame of pixel blocks through the input buffer / window calc path.
//   clk, n_rst   - clock, asynchronous active-low reset
//   start        - begin a frame (only honoured while idle)
//   abort        - synchronous return to idle from any state
//   in_valid     - upstream block available
//   in_ready     - block accepted this cycle when in_valid is also high
//   out_full     - downstream full; holds off new loads
//   calc_done    - one pulse per finished window calculation
//   load_enable  - one-cycle load strobe per accepted block
//   col_idx      - current block column
//   row_idx      - current block row
//   busy         - controller not idle
//   frame_done   - one-cycle pulse after the final window of the last block
//   err_stray    - sticky: calc_done arrived outside CALC
module frame_block_controller
  import frame_ctrl_pkg::*;
#(
  parameter int unsigned COLS         = 4,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned WIN_PER_LOAD = WIN_PER_LOAD_DEF,
  localparam int unsigned ColW = idx_width(COLS),
  localparam int unsigned RowW = idx_width(ROWS)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            out_full,
  input  logic            calc_done,
  output logic            load_enable,
  output logic [ColW-1:0] col_idx,
  output logic [RowW-1:0] row_idx,
  output logic            busy,
  output logic            frame_done,
  output logic            err_stray
);

  localparam int unsigned     WinW   = idx_width(WIN_PER_LOAD);
  localparam logic [WinW-1:0] WinMax = WinW'(WIN_PER_LOAD - 1);

  fbc_state_t      state_q, state_d;
  logic [WinW-1:0] win_cnt_q, win_cnt_d;
  logic            err_stray_q, err_stray_d;
  logic            pos_clear, pos_advance, last_block;

  block_position_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (pos_clear),
    .advance    (pos_advance),
    .col        (col_idx),
    .row        (row_idx),
    .last_block (last_block)
  );

  // in_ready is the only output that looks at an input directly.
  assign in_ready    = (state_q == WAIT_DATA) && !out_full;
  assign load_enable = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign err_stray   = err_stray_q;

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    err_stray_d = err_stray_q;
    pos_clear   = 1'b0;
    pos_advance = 1'b0;

    if (calc_done && (state_q != CALC)) begin
      err_stray_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_DATA;
          win_cnt_d   = '0;
          err_stray_d = 1'b0;
          pos_clear   = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (in_valid && in_ready) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        win_cnt_d = '0;
        state_d   = CALC;
      end
      CALC: begin
        if (calc_done) begin
          if (win_cnt_q == WinMax) begin
            win_cnt_d = '0;
            if (last_block) begin
              state_d = DONE;
            end else begin
              pos_advance = 1'b1;
              state_d     = WAIT_DATA;
            end
          end else begin
            win_cnt_d = win_cnt_q + WinW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything except the sticky error flag.
    if (abort) begin
      state_d     = IDLE;
      win_cnt_d   = '0;
      err_stray_d = err_stray_q;
      pos_clear   = 1'b1;
      pos_advance = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      err_stray_q <= err_stray_d;
    end
  end

endmodule

// File: tb/tb_frame_block_controller.sv
module tb_frame_block_controller;

  localparam int unsigned COLS = 3;
  localparam int unsigned ROWS = 2;
  localparam int unsigned WPL  = 4;
  localparam int unsigned NBLK = COLS * ROWS;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_full = 1'b0;
  logic       calc_done = 1'b0;
  logic       in_ready, load_enable, busy, frame_done, err_stray;
  logic [1:0] col_idx;
  logic [0:0] row_idx;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;
  int done_cnt = 0;

  frame_block_controller #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .WIN_PER_LOAD (WPL)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_full    (out_full),
    .calc_done   (calc_done),
    .load_enable (load_enable),
    .col_idx     (col_idx),
    .row_idx     (row_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_stray   (err_stray)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (load_enable === 1'b1) load_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  end

  // Reference position of block number blk in a row-major frame.
  function automatic int exp_col(input int blk);
    return blk % COLS;
  endfunction

  function automatic int exp_row(input int blk);
    return blk / COLS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 n_rst = 1'b0;
    #2;
    checks++;
    if ({busy, load_enable, frame_done, err_stray, in_ready, col_idx, row_idx} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {busy, load_enable, frame_done, err_stray, in_ready, col_idx, row_idx});
    end
    @(negedge clk) n_rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  // Feed one block from WAIT_DATA through its windows; checks load and position.
  task automatic run_block(input int blk, input bit last, input bit rnd);
    int stall;
    stall = rnd ? int'($urandom_range(0, 4)) : 0;
    for (int i = 0; i < stall; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        out_full = 1'b0;
      end else begin
        in_valid = 1'b1;
        out_full = 1'b1;
      end
      #1;
      checks++;
      if (in_ready !== ~out_full) begin
        errors++;
        $display("FAIL stall_ready blk%0d: got %b required %b", blk, in_ready, ~out_full);
      end
      tick();
      checks++;
      if (load_enable !== 1'b0) begin
        errors++;
        $display("FAIL stall_load blk%0d: got %b required 0", blk, load_enable);
      end
    end
    in_valid = 1'b1;
    out_full = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready blk%0d: got %b required 1", blk, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (load_enable !== 1'b1 || col_idx !== 2'(exp_col(blk)) || row_idx !== 1'(exp_row(blk)))
    begin
      errors++;
      $display("FAIL load blk%0d: got le=%b col=%0d row=%0d required le=1 col=%0d row=%0d",
               blk, load_enable, col_idx, row_idx, exp_col(blk), exp_row(blk));
    end
    tick();
    checks++;
    if (load_enable !== 1'b0) begin
      errors++;
      $display("FAIL load_width blk%0d: got %b required 0", blk, load_enable);
    end
    for (int w = 0; w < int'(WPL); w++) begin
      int gap;
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) tick();
      checks++;
      if (frame_done !== 1'b0 || load_enable !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL calc_quiet blk%0d w%0d: got fd=%b le=%b rdy=%b required 0 0 0",
                 blk, w, frame_done, load_enable, in_ready);
      end
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
    end
    if (last) begin
      checks++;
      if (frame_done !== 1'b1 || col_idx !== 2'(COLS - 1) || row_idx !== 1'(ROWS - 1)) begin
        errors++;
        $display("FAIL frame_done: got fd=%b col=%0d row=%0d required fd=1 col=%0d row=%0d",
                 frame_done, col_idx, row_idx, COLS - 1, ROWS - 1);
      end
      tick();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || col_idx !== 2'(COLS - 1) ||
          row_idx !== 1'(ROWS - 1)) begin
        errors++;
        $display("FAIL after_done: got fd=%b busy=%b col=%0d row=%0d required 0 0 %0d %0d",
                 frame_done, busy, col_idx, row_idx, COLS - 1, ROWS - 1);
      end
    end else begin
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b1 || col_idx !== 2'(exp_col(blk + 1)) ||
          row_idx !== 1'(exp_row(blk + 1)) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL advance blk%0d: got fd=%b busy=%b col=%0d row=%0d rdy=%b required 0 1 %0d %0d 1",
                 blk, frame_done, busy, col_idx, row_idx, in_ready,
                 exp_col(blk + 1), exp_row(blk + 1));
      end
    end
  endtask

  task automatic test_full_frame(input bit rnd);
    int l0, d0;
    l0 = load_cnt;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err_stray !== 1'b0 || col_idx !== 2'd0 || row_idx !== 1'd0) begin
      errors++;
      $display("FAIL frame_start: got busy=%b err=%b col=%0d row=%0d required 1 0 0 0",
               busy, err_stray, col_idx, row_idx);
    end
    for (int b = 0; b < int'(NBLK); b++) run_block(b, b == int'(NBLK) - 1, rnd);
    checks++;
    if (load_cnt - l0 != int'(NBLK) || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL frame_pulses: got loads=%0d dones=%0d required %0d 1",
               load_cnt - l0, done_cnt - d0, NBLK);
    end
  endtask

  task automatic test_backpressure();
    int l0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    out_full = 1'b1;
    l0 = load_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready c%0d: got %b required 0", i, in_ready);
      end
      tick();
      checks++;
      if (load_enable !== 1'b0) begin
        errors++;
        $display("FAIL bp_load c%0d: got %b required 0", i, load_enable);
      end
    end
    out_full = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (load_enable !== 1'b1 || load_cnt != l0) begin
      errors++;
      $display("FAIL bp_release_load: got le=%b loads=%0d required 1 %0d",
               load_enable, load_cnt - l0, 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_abort: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_stray();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    checks++;
    if (err_stray !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: got err=%b busy=%b required 1 0", err_stray, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err_stray !== 1'b0) begin
      errors++;
      $display("FAIL stray_clear: got %b required 0", err_stray);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    calc_done = 1'b1;  // lands while in LOAD
    tick();
    calc_done = 1'b0;
    checks++;
    if (err_stray !== 1'b1) begin
      errors++;
      $display("FAIL stray_load: got %b required 1", err_stray);
    end
    for (int w = 0; w < int'(WPL) - 1; w++) begin
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b0 || col_idx !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stray_wincnt: got rdy=%b col=%0d busy=%b required 0 0 1",
               in_ready, col_idx, busy);
    end
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || col_idx !== 2'd1) begin
      errors++;
      $display("FAIL stray_final_win: got rdy=%b col=%0d required 1 1", in_ready, col_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (err_stray !== 1'b1 || busy !== 1'b0 || col_idx !== 2'd0) begin
      errors++;
      $display("FAIL stray_abort_hold: got err=%b busy=%b col=%0d required 1 0 0",
               err_stray, busy, col_idx);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err_stray !== 1'b0) begin
      errors++;
      $display("FAIL stray_restart_clear: got %b required 0", err_stray);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int d0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_block(0, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int w = 0; w < 2; w++) begin
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
    end
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || col_idx !== 2'd0 || row_idx !== 1'd0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_calc: got busy=%b col=%0d row=%0d fd=%b required 0 0 0 0",
               busy, col_idx, row_idx, frame_done);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
    test_full_frame(1'b1);
  endtask

  task automatic test_start_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: got busy=%b required 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_block(0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    start = 1'b1;  // while in CALC on block 1
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || col_idx !== 2'd1) begin
      errors++;
      $display("FAIL start_busy_calc: got busy=%b col=%0d required 1 1", busy, col_idx);
    end
    for (int w = 0; w < int'(WPL); w++) begin
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
    end
    checks++;
    if (col_idx !== 2'd2 || row_idx !== 1'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_continue: got col=%0d row=%0d rdy=%b required 2 0 1",
               col_idx, row_idx, in_ready);
    end
    start = 1'b1;  // while in WAIT_DATA
    tick();
    start = 1'b0;
    checks++;
    if (col_idx !== 2'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_wait: got col=%0d rdy=%b required 2 1", col_idx, in_ready);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    checks++;
    if (err_stray !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got err=%b busy=%b required 1 1", err_stray, busy);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, load_enable, frame_done, err_stray, in_ready, col_idx, row_idx} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0000000",
               {busy, load_enable, frame_done, err_stray, in_ready, col_idx, row_idx});
    end
    @(negedge clk) n_rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_idle: got busy=%b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_backpressure();
    test_stray();
    test_abort();
    test_start_abort();
    test_async_reset();
    test_full_frame(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
